// File: rtl/pc_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Purpose  : Program-counter register and instruction-fetch controller for a
//            10-bit-address CPU. Owns the PC, issues single-word reads to
//            instruction memory, hands the fetched word to decode through a
//            valid/advance handshake, and selects the next PC (sequential,
//            PC-relative branch through the external pc_incr adder, or
//            absolute jump).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   adv_i          decode accepts the presented instruction
//   br_taken_i     take a PC-relative branch on this advance
//   br_disp_i      signed branch displacement relative to pc
//   jmp_i          take an absolute jump on this advance (beats br_taken_i)
//   jmp_addr_i     absolute jump target
//   imem_rd_en_o   instruction-memory read strobe (one cycle per request)
//   imem_addr_o    instruction-memory read address (always the current pc)
//   imem_valid_i   read data valid (only looked at while waiting)
//   imem_data_i    read data
//   instr_valid_o  instr_o / pc_o valid for decode
//   instr_o        registered fetched instruction
//   pc_o           address of instr_o
//   link_pc_o      pc_o + 1 (return address)
//   fetch_err_o    one-cycle pulse on each fetch timeout
//   inc_curr_o     pc_incr current PC (equals pc_o)
//   inc_decr_o     pc_incr direction (1 = subtract)
//   inc_diff_o     pc_incr unsigned magnitude
//   inc_next_i     pc_incr result
// ============================================================================
module pc_fetch #(
    parameter logic [9:0] RESET_PC = 10'd0,
    parameter int         INSTR_W  = 16,
    parameter int         TIMEOUT  = 15     // 1..255
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               adv_i,
    input  logic               br_taken_i,
    input  logic [9:0]         br_disp_i,
    input  logic               jmp_i,
    input  logic [9:0]         jmp_addr_i,
    output logic               imem_rd_en_o,
    output logic [9:0]         imem_addr_o,
    input  logic               imem_valid_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [9:0]         pc_o,
    output logic [9:0]         link_pc_o,
    output logic               fetch_err_o,
    output logic [9:0]         inc_curr_o,
    output logic               inc_decr_o,
    output logic [9:0]         inc_diff_o,
    input  logic [9:0]         inc_next_i
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t               state_q;
    logic [9:0]           pc_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [7:0]           wait_cnt_q;
    logic                 rd_en_q;
    logic                 instr_valid_q;
    logic                 fetch_err_q;

    logic                 w_disp_neg;
    logic [9:0]           w_disp_mag;
    logic [9:0]           pc_d;
    logic [7:0]           wait_cnt_inc;

    // ------------------------------------------------------------------
    // Incrementer drive. Always active; pc only samples the result on an
    // advance. The two's-complement negation of -512 stays 10'h200, which
    // is exactly the magnitude the adder needs.
    // ------------------------------------------------------------------
    always_comb begin
        w_disp_neg = br_disp_i[9];
        w_disp_mag = w_disp_neg ? (~br_disp_i + 10'd1) : br_disp_i;
        inc_decr_o = br_taken_i & w_disp_neg;
        inc_diff_o = br_taken_i ? w_disp_mag : 10'd1;
        // Jump wins over branch; the adder result is then ignored.
        pc_d       = jmp_i ? jmp_addr_i : inc_next_i;
    end

    assign wait_cnt_inc = wait_cnt_q + 8'd1;

    // ------------------------------------------------------------------
    // Fetch FSM with registered strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            wait_cnt_q    <= 8'd0;
            rd_en_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            rd_en_q     <= 1'b0;
            fetch_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    rd_en_q <= 1'b1;
                end
                S_REQ: begin
                    wait_cnt_q <= 8'd0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == C_TIMEOUT) begin
                        // fetch_err is showing this cycle; abandon the read
                        // and retry the same pc.
                        state_q <= S_REQ;
                        rd_en_q <= 1'b1;
                    end else if (imem_valid_i) begin
                        instr_q       <= imem_data_i;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_ISSUE;
                    end else begin
                        wait_cnt_q <= wait_cnt_inc;
                        if (wait_cnt_inc == C_TIMEOUT) begin
                            fetch_err_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (adv_i) begin
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                        rd_en_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_rd_en_o  = rd_en_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign link_pc_o     = pc_q + 10'd1;
    assign fetch_err_o   = fetch_err_q;
    assign inc_curr_o    = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch
// Purpose  : Self-checking bench for pc_fetch. A reference model of the PC
//            predicts every fetch address/cycle, every issued instruction
//            and every timeout; a monitor pops those expectations when the
//            DUT presents strobes. Also models the external pc_incr adder
//            and an instruction memory with variable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    localparam logic [9:0] RESET_PC = 10'd0;
    localparam int         INSTR_W  = 16;
    localparam int         TIMEOUT  = 15;

    logic               clk        = 1'b0;
    logic               reset      = 1'b0;
    logic               adv        = 1'b0;
    logic               br_taken   = 1'b0;
    logic [9:0]         br_disp    = '0;
    logic               jmp        = 1'b0;
    logic [9:0]         jmp_addr   = '0;
    logic               imem_valid = 1'b0;
    logic [INSTR_W-1:0] imem_data  = '0;
    logic               imem_rd_en, instr_valid, fetch_err, inc_decr;
    logic [9:0]         imem_addr, pc, link_pc, inc_curr, inc_diff, inc_next;
    logic [INSTR_W-1:0] instr;

    pc_fetch #(.RESET_PC(RESET_PC), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset), .adv_i(adv), .br_taken_i(br_taken),
        .br_disp_i(br_disp), .jmp_i(jmp), .jmp_addr_i(jmp_addr),
        .imem_rd_en_o(imem_rd_en), .imem_addr_o(imem_addr),
        .imem_valid_i(imem_valid), .imem_data_i(imem_data),
        .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc),
        .link_pc_o(link_pc), .fetch_err_o(fetch_err), .inc_curr_o(inc_curr),
        .inc_decr_o(inc_decr), .inc_diff_o(inc_diff), .inc_next_i(inc_next)
    );

    // External pc_incr adder (mod 1024).
    assign inc_next = inc_decr ? (inc_curr - inc_diff) : (inc_curr + inc_diff);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int addr; int cyc; } fexp_t;
    typedef struct { int pc; int data; int cyc; } iexp_t;

    fexp_t fq[$];     // expected fetches
    iexp_t iq[$];     // expected issued instructions
    int    eq[$];     // expected fetch_err cycles

    logic [INSTR_W-1:0] mem [1024];

    // Memory behaviour knobs set by the stimulus thread.
    int next_lat = 1;
    int drop_req = 0;

    int model_pc = 0;

    // ------------------------------------------------------------------
    // Memory responder + monitor (one process so ordering is fixed).
    // ------------------------------------------------------------------
    initial begin : mon
        bit    pending = 0, stale = 0, outstanding = 0, prev_iv = 0, have_cur = 0;
        int    delay = 0, req_exp = 0, req_addr = 0, drop_done = 0;
        fexp_t e, r;
        iexp_t cur;
        cur = '{0, 0, 0};
        forever begin
            @(posedge clk); #1;
            if (pending) begin
                delay--;
                if (delay == 0) begin
                    imem_valid  = 1'b1;
                    imem_data   = mem[req_addr];
                    pending     = 0;
                    outstanding = 0;
                    if (!stale) iq.push_back('{req_exp, int'(mem[req_exp]), cyc + 1});
                end else begin
                    imem_valid = 1'b0;
                end
            end else if (!outstanding && $urandom_range(0, 3) == 0) begin
                // Stray responses outside WAIT must be ignored.
                imem_valid = 1'b1;
                imem_data  = INSTR_W'($urandom);
            end else begin
                imem_valid = 1'b0;
            end

            @(negedge clk);
            if (reset) begin
                fq.delete(); iq.delete(); eq.delete();
                have_cur = 0; prev_iv = 0;
                if (pending) stale = 1;
            end else begin
                while (fq.size() > 0 && fq[0].cyc < cyc) begin
                    e = fq.pop_front();
                    chk("fetch_missing", cyc, e.cyc);
                end
                if (imem_rd_en) begin
                    if (instr_valid) chk("rd_en_with_valid", 1, 0);
                    if (fq.size() == 0) begin
                        chk("unexpected_fetch", int'(imem_addr), -1);
                    end else begin
                        e = fq.pop_front();
                        chk("fetch_addr", int'(imem_addr), e.addr);
                        chk("fetch_cycle", cyc, e.cyc);
                        outstanding = 1;
                        stale       = 0;
                        if (drop_done < drop_req) begin
                            drop_done++;
                            pending = 0;
                            r.addr  = e.addr;
                            r.cyc   = cyc + TIMEOUT + 2;
                            fq.push_back(r);
                            eq.push_back(cyc + TIMEOUT + 1);
                        end else begin
                            pending  = 1;
                            delay    = next_lat;
                            req_exp  = e.addr;
                            req_addr = int'(imem_addr);
                        end
                    end
                end
                while (eq.size() > 0 && eq[0] < cyc) chk("fetch_err_missing", cyc, eq.pop_front());
                if (fetch_err) begin
                    if (eq.size() == 0) chk("unexpected_fetch_err", cyc, -1);
                    else                chk("fetch_err_cycle", cyc, eq.pop_front());
                end
                while (iq.size() > 0 && iq[0].cyc < cyc) begin
                    cur = iq.pop_front();
                    chk("issue_missing", cyc, cur.cyc);
                end
                if (instr_valid && !prev_iv) begin
                    if (iq.size() == 0) begin
                        chk("unexpected_issue", int'(pc), -1);
                        have_cur = 0;
                    end else begin
                        cur = iq.pop_front();
                        chk("issue_cycle", cyc, cur.cyc);
                        have_cur = 1;
                    end
                end
                if (instr_valid && have_cur) begin
                    chk("instr", int'(instr), cur.data);
                    chk("pc", int'(pc), cur.pc);
                end
                prev_iv = instr_valid;
                chk("link_pc", int'(link_pc), (int'(pc) + 1) % 1024);
                chk("inc_curr", int'(inc_curr), int'(pc));
            end
        end
    end

    // ------------------------------------------------------------------
    // One advance: wait for an instruction, stall, then accept it with
    // the given next-PC controls. The expected next fetch is pushed here.
    // ------------------------------------------------------------------
    task automatic do_adv(input bit j, input bit b, input logic [9:0] d,
                          input logic [9:0] ja, input int stall,
                          input int lat, input bit drop);
        int    w;
        int    sd;
        int    nxt;
        fexp_t e;
        w = 0;
        while (!instr_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!instr_valid) begin
            chk("issue_wait_timeout", 0, 1);
            return;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        sd = d[9] ? int'(d) - 1024 : int'(d);
        if (j)      nxt = int'(ja);
        else if (b) nxt = ((model_pc + sd) % 1024 + 1024) % 1024;
        else        nxt = (model_pc + 1) % 1024;
        adv = 1'b1; jmp = j; br_taken = b; br_disp = d; jmp_addr = ja;
        next_lat = lat;
        if (drop) drop_req++;
        e.addr = nxt;
        e.cyc  = cyc + 1;
        fq.push_back(e);
        @(negedge clk);
        if (!j) begin
            chk("inc_decr", int'(inc_decr), (b && sd < 0) ? 1 : 0);
            chk("inc_diff", int'(inc_diff), b ? ((sd < 0) ? -sd : sd) : 1);
        end
        @(posedge clk); #1;
        adv      = 1'b0;
        jmp      = 1'($urandom);
        br_taken = 1'($urandom);
        br_disp  = 10'($urandom);
        jmp_addr = 10'($urandom);
        model_pc = nxt;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        fexp_t e;
        for (int i = 0; i < 1024; i++) mem[i] = INSTR_W'($urandom);

        #1 reset = 1'b1;
        #1;
        chk("rst_pc", int'(pc), int'(RESET_PC));
        chk("rst_instr", int'(instr), 0);
        chk("rst_instr_valid", int'(instr_valid), 0);
        chk("rst_rd_en", int'(imem_rd_en), 0);
        chk("rst_fetch_err", int'(fetch_err), 0);
        chk("rst_imem_addr", int'(imem_addr), int'(RESET_PC));
        chk("rst_link_pc", int'(link_pc), (int'(RESET_PC) + 1) % 1024);

        @(posedge clk); @(posedge clk); #2;
        reset    = 1'b0;
        model_pc = int'(RESET_PC);
        next_lat = 1;
        e.addr = int'(RESET_PC); e.cyc = cyc + 1;
        fq.push_back(e);
        @(posedge clk); #1;

        // Sequential fetch 0,1,2,3 at full rate.
        do_adv(0, 0, 10'd0, 10'd0, 0, 1, 0);
        do_adv(0, 0, 10'd0, 10'd0, 0, 1, 0);
        do_adv(0, 0, 10'd0, 10'd0, 0, 1, 0);
        do_adv(1, 0, 10'd0, 10'd10, 0, 1, 0);        // -> 10
        do_adv(0, 1, 10'd5, 10'd0, 0, 1, 0);         // 10 + 5 -> 15
        do_adv(0, 1, 10'h3FD, 10'd0, 0, 1, 0);       // 15 - 3 -> 12
        do_adv(1, 0, 10'd0, 10'd1023, 0, 1, 0);      // -> 1023
        do_adv(0, 0, 10'd0, 10'd0, 0, 1, 0);         // wrap -> 0
        do_adv(0, 1, 10'h200, 10'd0, 0, 1, 0);       // 0 - 512 -> 512
        do_adv(1, 1, 10'h155, 10'd700, 0, 1, 0);     // jump beats branch -> 700
        do_adv(0, 0, 10'd0, 10'd0, 5, 1, 1);         // stall 5, then timeout on 701

        for (int k = 0; k < 60; k++) begin
            do_adv($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                   10'($urandom), 10'($urandom), $urandom_range(0, 3),
                   $urandom_range(1, 4), $urandom_range(0, 19) == 0);
        end

        // Reset in the middle of a WAIT with a response still in flight.
        do_adv(0, 0, 10'd0, 10'd0, 0, 2, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst_instr_valid", int'(instr_valid), 0);
        chk("midrst_pc", int'(pc), int'(RESET_PC));
        chk("midrst_rd_en", int'(imem_rd_en), 0);
        chk("midrst_instr", int'(instr), 0);
        @(posedge clk); #2;
        reset    = 1'b0;
        model_pc = int'(RESET_PC);
        next_lat = 1;
        e.addr = int'(RESET_PC); e.cyc = cyc + 1;
        fq.push_back(e);
        @(posedge clk); #1;
        do_adv(0, 0, 10'd0, 10'd0, 0, 1, 0);
        do_adv(0, 1, 10'h3FF, 10'd0, 0, 1, 0);       // 1 - 1 -> 0
        do_adv(0, 0, 10'd0, 10'd0, 0, 1, 0);

        repeat (10) @(posedge clk);
        #1;
        chk("fetch_queue_drained", fq.size(), 0);
        chk("issue_queue_drained", iq.size(), 0);
        chk("err_queue_drained", eq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
